// File: rtl/mem_seg.sv
// mem_seg -- memory-access pipeline stage.
//
// Takes the EX/MEM latch (IRi, ALUi, Bi, cond) and produces the MEM/WB latch
// (IRo, ALUo, LMDo). Loads and stores go to the data memory over a req/ack
// handshake, and upstream stages are stalled until the access completes.
// Taken branches and jumps are signalled to fetch through pc_sel/pc_tgt.
//
// Optional feature: define MEM_BYTE_OPS_EN to add LB/LBU/SB byte accesses.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   IRi/ALUi/Bi/cond   EX/MEM latch inputs
//   stall      hold EX/MEM and upstream (combinational)
//   pc_sel     taken branch/jump (combinational), pc_tgt = ALUi
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata   registered memory request
//   dm_rdata/dm_ack   memory response
//   IRo/ALUo/LMDo   MEM/WB latch
//   align_err  one-cycle pulse for a misaligned word access
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no access outstanding; instructions pass through or issue
// S_REQ  | request on the bus, waiting for dm_ack

module mem_seg #(
  parameter logic [31:0] NOP_IR = 32'h0000_0000,
  parameter logic [5:0]  OP_LW  = 6'b100011,
  parameter logic [5:0]  OP_SW  = 6'b101011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IRi,
  input  logic [31:0] ALUi,
  input  logic [31:0] Bi,
  input  logic        cond,
  output logic        stall,
  output logic        pc_sel,
  output logic [31:0] pc_tgt,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic [31:0] IRo,
  output logic [31:0] ALUo,
  output logic [31:0] LMDo,
  output logic        align_err
);

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
`ifdef MEM_BYTE_OPS_EN
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SB  = 6'b101000;
`endif

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t      state, state_nxt;
  logic [5:0]  opcode;
  logic        is_ld, is_st, is_mem, is_br, misalign;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, load_val;

  logic        req_nxt, we_nxt, align_nxt;
  logic [3:0]  be_nxt;
  logic [31:0] addr_nxt, wdata_nxt, ir_nxt, alu_nxt, lmd_nxt;

  assign opcode = IRi[31:26];
  assign pc_tgt = ALUi;

  // Decode. IRi/ALUi stay frozen while stalled, so they remain valid in S_REQ.
  always_comb begin
    is_ld      = (opcode == OP_LW);
    is_st      = (opcode == OP_SW);
    misalign   = (is_ld | is_st) & (ALUi[1:0] != 2'b00);
    be_calc    = 4'b1111;
    wdata_calc = Bi;
    load_val   = dm_rdata;
`ifdef MEM_BYTE_OPS_EN
    // Byte ops never fault; the lane is picked from the address low bits.
    if (opcode == OP_LB || opcode == OP_LBU || opcode == OP_SB) begin
      is_ld      = (opcode != OP_SB);
      is_st      = (opcode == OP_SB);
      be_calc    = 4'b0001 << ALUi[1:0];
      wdata_calc = {4{Bi[7:0]}};
      case (ALUi[1:0])
        2'd0:    load_val = {24'h0, dm_rdata[7:0]};
        2'd1:    load_val = {24'h0, dm_rdata[15:8]};
        2'd2:    load_val = {24'h0, dm_rdata[23:16]};
        default: load_val = {24'h0, dm_rdata[31:24]};
      endcase
      if (opcode == OP_LB) load_val[31:8] = {24{load_val[7]}};
    end
`endif
    is_mem = is_ld | is_st;
    is_br  = (((opcode == OP_BEQ) || (opcode == OP_BNE)) && cond) || (opcode == OP_J);
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    pc_sel    = 1'b0;
    req_nxt   = dm_req;
    we_nxt    = dm_we;
    be_nxt    = dm_be;
    addr_nxt  = dm_addr;
    wdata_nxt = dm_wdata;
    ir_nxt    = IRo;
    alu_nxt   = ALUo;
    lmd_nxt   = LMDo;
    align_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        pc_sel = is_br;
        if (is_mem && !misalign) begin
          stall     = 1'b1;
          req_nxt   = 1'b1;
          we_nxt    = is_st;
          be_nxt    = be_calc;
          addr_nxt  = {ALUi[31:2], 2'b00};
          wdata_nxt = wdata_calc;
          ir_nxt    = NOP_IR;
          state_nxt = S_REQ;
        end else begin
          // Misaligned ops pass through like ALU ops; the store never reaches the bus.
          ir_nxt    = IRi;
          alu_nxt   = ALUi;
          lmd_nxt   = 32'h0;
          align_nxt = is_mem;
        end
      end
      S_REQ: begin
        stall = ~dm_ack;
        if (dm_ack) begin
          lmd_nxt   = is_ld ? load_val : 32'h0;
          ir_nxt    = IRi;
          alu_nxt   = ALUi;
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          be_nxt    = 4'b0000;
          state_nxt = S_IDLE;
        end else begin
          ir_nxt = NOP_IR;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_be     <= 4'b0000;
      dm_addr   <= 32'h0;
      dm_wdata  <= 32'h0;
      IRo       <= NOP_IR;
      ALUo      <= 32'h0;
      LMDo      <= 32'h0;
      align_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      dm_req    <= req_nxt;
      dm_we     <= we_nxt;
      dm_be     <= be_nxt;
      dm_addr   <= addr_nxt;
      dm_wdata  <= wdata_nxt;
      IRo       <= ir_nxt;
      ALUo      <= alu_nxt;
      LMDo      <= lmd_nxt;
      align_err <= align_nxt;
    end
  end

endmodule

// File: tb/tb_mem_seg.sv
// Testbench for mem_seg: directed scenarios followed by random instructions,
// each checked against a per-instruction behavioural model.
module tb_mem_seg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IRi, ALUi, Bi, dm_rdata;
  logic        cond, dm_ack;
  logic        stall, pc_sel, dm_req, dm_we, align_err;
  logic [31:0] pc_tgt, dm_addr, dm_wdata, IRo, ALUo, LMDo;
  logic [3:0]  dm_be;

  int n_cmp = 0;
  int n_err = 0;

  mem_seg dut (
    .clk(clk), .rst(rst), .IRi(IRi), .ALUi(ALUi), .Bi(Bi), .cond(cond),
    .stall(stall), .pc_sel(pc_sel), .pc_tgt(pc_tgt),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .IRo(IRo), .ALUo(ALUo), .LMDo(LMDo), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction to completion; dly = number of REQ cycles before ack.
  task automatic exec(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] b,
                      input logic c, input int dly, input logic [31:0] rd);
    logic [5:0]  op;
    logic        ld, st, byte_op, mem, mis, br;
    logic [3:0]  be;
    logic [31:0] wd, lmd;
    logic [7:0]  sel;
    int          nstall;
    op      = ir[31:26];
    ld      = (op == 6'b100011);
    st      = (op == 6'b101011);
    byte_op = 1'b0;
`ifdef MEM_BYTE_OPS_EN
    if (op == 6'b100000 || op == 6'b100100) begin ld = 1'b1; byte_op = 1'b1; end
    if (op == 6'b101000) begin st = 1'b1; byte_op = 1'b1; end
`endif
    mem = ld | st;
    mis = mem && !byte_op && (alu[1:0] != 2'b00);
    br  = (((op == 6'b000100) || (op == 6'b000101)) && c) || (op == 6'b000010);
    be  = byte_op ? (4'b0001 << alu[1:0]) : 4'b1111;
    wd  = byte_op ? {4{b[7:0]}} : b;
    sel = 8'(rd >> (8 * alu[1:0]));
    lmd = 32'h0;
    if (ld) begin
      if (!byte_op)             lmd = rd;
      else if (op == 6'b100000) lmd = {{24{sel[7]}}, sel};
      else                      lmd = {24'h0, sel};
    end

    IRi = ir; ALUi = alu; Bi = b; cond = c; dm_ack = 1'b0;
    #2;
    chk("pc_sel", pc_sel, br);
    chk("pc_tgt", pc_tgt, alu);
    if (!mem || mis) begin
      chk("stall_pass", stall, 0);
      tick();
      chk("IRo_pass", IRo, ir);
      chk("ALUo_pass", ALUo, alu);
      chk("LMDo_pass", LMDo, 0);
      chk("align_err", align_err, mis);
      chk("dm_req_pass", dm_req, 0);
      chk("dm_we_pass", dm_we, 0);
    end else begin
      nstall = 0;
      if (stall) nstall++;
      tick();
      chk("dm_req_issue", dm_req, 1);
      chk("dm_we", dm_we, st);
      chk("dm_be", dm_be, be);
      chk("dm_addr", dm_addr, {alu[31:2], 2'b00});
      chk("dm_wdata", dm_wdata, wd);
      chk("IRo_issue", IRo, NOP);
      chk("align_err_mem", align_err, 0);
      for (int k = 0; k < dly; k++) begin
        #1;
        chk("pc_sel_req", pc_sel, 0);
        if (stall) nstall++;
        tick();
        chk("IRo_wait", IRo, NOP);
        chk("dm_req_hold", dm_req, 1);
        chk("dm_addr_hold", dm_addr, {alu[31:2], 2'b00});
      end
      dm_ack = 1'b1; dm_rdata = rd;
      #1;
      chk("stall_ack", stall, 0);
      tick();
      chk("LMDo", LMDo, lmd);
      chk("IRo_done", IRo, ir);
      chk("ALUo_done", ALUo, alu);
      chk("dm_req_done", dm_req, 0);
      chk("dm_we_done", dm_we, 0);
      chk("dm_be_done", dm_be, 0);
      chk("stall_cycles", nstall, dly + 1);
      dm_ack = 1'b0; dm_rdata = $urandom;
    end
  endtask

  initial begin
    logic [5:0]  ops [9];
    logic [31:0] a;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
            6'b000010, 6'b100000, 6'b100100, 6'b101000};

    rst = 1'b0; IRi = NOP; ALUi = 0; Bi = 0; cond = 0; dm_ack = 0; dm_rdata = 0;
    #1;
    chk("rst_IRo", IRo, NOP);
    chk("rst_LMDo", LMDo, 0);
    chk("rst_dm_req", dm_req, 0);
    chk("rst_dm_be", dm_be, 0);
    chk("rst_align", align_err, 0);
    #22 rst = 1'b1;
    tick();

    exec(32'h0022_1820, 32'd5, 32'h0, 1'b0, 0, 32'h0);              // ADD
    exec({6'b100011, 26'h0}, 32'h10, 32'h0, 1'b0, 3, 32'hDEAD_BEEF); // LW, 3-cycle ack delay
    exec({6'b101011, 26'h0}, 32'h20, 32'h1234_5678, 1'b0, 0, 32'hFFFF_FFFF); // SW, immediate ack
    exec({6'b100011, 26'h0}, 32'h13, 32'h0, 1'b0, 0, 32'h0);       // misaligned LW
    exec({6'b101011, 26'h0}, 32'h22, 32'h55, 1'b0, 0, 32'h0);      // misaligned SW
    exec({6'b000100, 26'h0}, 32'h40, 32'h0, 1'b1, 0, 32'h0);       // BEQ taken
    exec({6'b000100, 26'h0}, 32'h40, 32'h0, 1'b0, 0, 32'h0);       // BEQ not taken
    exec({6'b000010, 26'h0}, 32'h80, 32'h0, 1'b0, 0, 32'h0);       // J
    exec({6'b100011, 26'h0}, 32'h44, 32'h0, 1'b0, 1, 32'hCAFE_0001); // back-to-back LW
    exec({6'b100011, 26'h0}, 32'h48, 32'h0, 1'b0, 0, 32'hCAFE_0002);

    // Reset while a request is outstanding.
    IRi = {6'b100011, 26'h0}; ALUi = 32'h30; dm_ack = 1'b0;
    tick();
    chk("mid_req_issued", dm_req, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_dm_req", dm_req, 0);
    chk("mid_rst_IRo", IRo, NOP);
    IRi = NOP; ALUi = 0;
    #2 rst = 1'b1;
    dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
    tick();
    chk("late_ack_LMDo", LMDo, 0);
    chk("late_ack_dm_req", dm_req, 0);
    dm_ack = 1'b0;

    for (int i = 0; i < 80; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      exec({ops[$urandom_range(0, 8)], 26'($urandom)}, a, $urandom,
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_seg.md
Name: mem_seg

Overview:
- Memory-access pipeline stage; consumes the EX/MEM latch (IRi, ALUi, Bi, cond) produced by the execute segment and drives the MEM/WB latch (IRo, ALUo, LMDo).
- Issues loads/stores to the data memory over a req/ack handshake and stalls upstream until the access completes.
- Resolves taken branches and jumps toward the fetch stage.

Parameters:
- NOP_IR, 32'h0000_0000: bubble instruction written to IRo on reset and on stall cycles.
- OP_LW, 6'b100011: load-word opcode (IRi[31:26]).
- OP_SW, 6'b101011: store-word opcode.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- IRi, input, 32: instruction from EX/MEM.
- ALUi, input, 32: ALU result; effective address for memory ops, target for branch/jump.
- Bi, input, 32: store data.
- cond, input, 1: branch condition from EX.
- stall, output, 1: holds EX/MEM and upstream stages; combinational.
- pc_sel, output, 1: taken branch/jump to fetch; combinational.
- pc_tgt, output, 32: equals ALUi.
- dm_req, output, 1: memory request (registered).
- dm_we, output, 1: 1 = write (registered).
- dm_be, output, 4: byte enables (registered).
- dm_addr, output, 32: word-aligned address, {ALUi[31:2],2'b00} (registered).
- dm_wdata, output, 32: write data (registered).
- dm_rdata, input, 32: read data, valid when dm_ack=1.
- dm_ack, input, 1: access complete.
- IRo, output, 32: MEM/WB instruction.
- ALUo, output, 32: MEM/WB ALU value.
- LMDo, output, 32: MEM/WB load data.
- align_err, output, 1: one-cycle pulse on a misaligned memory op.

Behaviour:
- Reset (rst=0, async): state=IDLE; IRo=NOP_IR; ALUo, LMDo, dm_addr, dm_wdata = 0; dm_req, dm_we, align_err = 0; dm_be=4'b0000. Any dm_ack arriving after reset is ignored in IDLE.
- Decode:
  - is_mem = opcode in {OP_LW, OP_SW} (plus byte ops with the optional feature).
  - is_br = BEQ 6'b000100 or BNE 6'b000101 with cond=1, or J 6'b000010 regardless of cond.
- State IDLE, non-memory instruction:
  - stall=0.
  - Next edge: IRo<=IRi, ALUo<=ALUi, LMDo<=0. One-cycle latency.
- State IDLE, memory instruction, aligned (ALUi[1:0]=0):
  - stall=1.
  - Next edge: dm_req<=1, dm_we<=(SW), dm_be<=4'b1111, dm_addr, dm_wdata<=Bi, IRo<=NOP_IR, go to REQ.
- State IDLE, memory instruction, misaligned:
  - No bus access; stall=0.
  - Next edge: IRo<=IRi, ALUo<=ALUi, LMDo<=0, align_err<=1 for one cycle. A store is suppressed.
- State REQ:
  - Bus outputs are held stable; stall = ~dm_ack.
  - Edge with dm_ack=0: IRo<=NOP_IR.
  - Edge with dm_ack=1: LMDo<=dm_rdata (load) or 0 (store); IRo<=IRi, ALUo<=ALUi; dm_req<=0, dm_we<=0, dm_be<=0; go to IDLE.
  - Minimum memory-op latency is 2 cycles.
- pc_sel = (state==IDLE) & is_br. Always 0 in REQ.
- align_err is 0 on every cycle not described above.
- Back-to-back memory ops: after an ack, state is IDLE for at least one cycle before the next request, so dm_req is low for ≥1 cycle between accesses.
- Reset asserted mid-REQ: request dropped immediately; the pending instruction is lost; the upstream re-issue policy belongs to the hazard unit.

Optional Feature:
- Macro: MEM_BYTE_OPS_EN.
- Defined:
  - Adds LB 6'b100000, LBU 6'b100100, SB 6'b101000 as memory ops; no alignment check for these.
  - dm_be = 4'b0001 << ALUi[1:0].
  - SB: dm_wdata = {4{Bi[7:0]}}.
  - LB: LMDo = sign-extended selected byte of dm_rdata. LBU: zero-extended.
- Undefined: these opcodes are treated as non-memory (single-cycle pass-through); dm_be is only ever 4'b1111 or 4'b0000.

Test Plan:
- Reset then ADD (IRi=32'h0022_1820, ALUi=5):
  - stall=0.
  - Next edge: IRo=32'h0022_1820, ALUo=5, LMDo=0.
- LW, ALUi=32'h0000_0010, dm_ack delayed 3 cycles, dm_rdata=32'hDEAD_BEEF:
  - dm_req rises 1 edge after issue; dm_addr=32'h10; stall high 4 cycles; IRo=NOP_IR meanwhile.
  - On ack edge: LMDo=32'hDEAD_BEEF; dm_req=0.
- SW, ALUi=32'h20, Bi=32'h1234_5678, ack in first REQ cycle:
  - dm_we=1, dm_wdata=32'h1234_5678, dm_be=4'hF.
  - Total 2 cycles; LMDo=0.
- LW with ALUi=32'h0000_0013:
  - No dm_req; align_err pulses 1 cycle; IRo=IRi.
- BEQ cond=1, ALUi=32'h40: pc_sel=1, pc_tgt=32'h40. BEQ cond=0: pc_sel=0. J with cond=0: pc_sel=1.
- rst pulsed low during REQ:
  - dm_req=0 and IRo=NOP_IR immediately.
  - A subsequent dm_ack=1 causes no change in LMDo.
